// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multicycle sequencer and the datapath (PC, IR, regfile, ALU, data memory).
interface multicycle_sequencer_if;
  logic [5:0] op;
  logic       zero;
  logic       sign;
  logic       PCWre;
  logic       IRWre;
  logic       InsMemRW;
  logic       RegWre;
  logic       DataMemRW;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic       ALUM2Reg;
  logic       WrRegData;
  logic [1:0] ExtSel;
  logic [1:0] PCSrc;
  logic [1:0] RegOut;
  logic [2:0] ALUOp;
  logic [2:0] state;
  logic       illegal_op;

  modport master (
    input  op, zero, sign,
    output PCWre, IRWre, InsMemRW, RegWre, DataMemRW, ALUSrcA, ALUSrcB,
           ALUM2Reg, WrRegData, ExtSel, PCSrc, RegOut, ALUOp, state, illegal_op
  );

  modport slave (
    output op, zero, sign,
    input  PCWre, IRWre, InsMemRW, RegWre, DataMemRW, ALUSrcA, ALUSrcB,
           ALUM2Reg, WrRegData, ExtSel, PCSrc, RegOut, ALUOp, state, illegal_op
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Moore control FSM stepping the multicycle datapath through IF/ID/EXE/MEM/WB.
// Strobes are decoded from the current state and the IR opcode, and are forced low while Reset is held.
module multicycle_sequencer #(
  parameter logic [5:0] HALT_OP     = 6'b111111,
  parameter logic [1:0] JAL_REG_SEL = 2'b00
) (
  input logic                    CLK,
  input logic                    Reset,
  multicycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  typedef enum logic [2:0] {C_NONE, C_ALU, C_LS, C_BR, C_JMP, C_HALT} cls_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_OR    = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;

  state_t cur;
  cls_t   cls;
  logic   taken;

  always_comb begin
    cls = C_NONE;
    case (bus.op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
      OP_ADDIU, OP_ANDI, OP_ORI, OP_SLL:   cls = C_ALU;
      OP_LW, OP_SW:                        cls = C_LS;
      OP_BEQ, OP_BNE, OP_BLTZ:             cls = C_BR;
      OP_J, OP_JR, OP_JAL:                 cls = C_JMP;
      default:                             cls = C_NONE;
    endcase
    if (bus.op == HALT_OP) cls = C_HALT;
  end

  always_comb begin
    taken = 1'b0;
    case (bus.op)
      OP_BEQ:  taken = bus.zero;
      OP_BNE:  taken = ~bus.zero;
      OP_BLTZ: taken = bus.sign;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cur <= S_IF;
    end else begin
      case (cur)
        S_IF: cur <= S_ID;
        S_ID: begin
          case (cls)
            C_ALU:   cur <= S_EXE_AL;
            C_LS:    cur <= S_EXE_LS;
            C_BR:    cur <= S_EXE_BR;
            C_HALT:  cur <= S_ID;
            default: cur <= S_IF;
          endcase
        end
        S_EXE_AL: cur <= S_WB_AL;
        S_EXE_LS: cur <= S_MEM;
        S_MEM:    cur <= (bus.op == OP_LW) ? S_WB_LD : S_IF;
        default:  cur <= S_IF;
      endcase
    end
  end

  assign bus.state = cur;

  // Reset gates every strobe combinationally so nothing writes while it is held.
  always_comb begin
    bus.PCWre      = 1'b0;
    bus.IRWre      = 1'b0;
    bus.InsMemRW   = 1'b0;
    bus.RegWre     = 1'b0;
    bus.DataMemRW  = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 1'b0;
    bus.ALUM2Reg   = 1'b0;
    bus.WrRegData  = 1'b0;
    bus.ExtSel     = 2'b00;
    bus.PCSrc      = 2'b00;
    bus.RegOut     = 2'b00;
    bus.ALUOp      = 3'b000;
    bus.illegal_op = 1'b0;
    if (Reset) begin
      bus.WrRegData = 1'b1;
      if (cur == S_IF) begin
        bus.IRWre    = 1'b1;
        bus.InsMemRW = 1'b1;
      end else begin
        case (bus.op)
          OP_ADD:   begin bus.ALUOp = 3'b000; bus.RegOut = 2'b10; end
          OP_SUB:   begin bus.ALUOp = 3'b001; bus.RegOut = 2'b10; end
          OP_AND:   begin bus.ALUOp = 3'b100; bus.RegOut = 2'b10; end
          OP_OR:    begin bus.ALUOp = 3'b011; bus.RegOut = 2'b10; end
          OP_SLT:   begin bus.ALUOp = 3'b110; bus.RegOut = 2'b10; end
          OP_ADDIU: begin bus.ALUOp = 3'b000; bus.ALUSrcB = 1'b1; bus.ExtSel = 2'b01; bus.RegOut = 2'b01; end
          OP_ANDI:  begin bus.ALUOp = 3'b100; bus.ALUSrcB = 1'b1; bus.RegOut = 2'b01; end
          OP_ORI:   begin bus.ALUOp = 3'b011; bus.ALUSrcB = 1'b1; bus.RegOut = 2'b01; end
          OP_SLL:   begin bus.ALUOp = 3'b010; bus.ALUSrcA = 1'b1; bus.ALUSrcB = 1'b1; bus.RegOut = 2'b10; end
          OP_LW, OP_SW: begin
            bus.ALUOp = 3'b000; bus.ALUSrcB = 1'b1; bus.ExtSel = 2'b01; bus.RegOut = 2'b01;
          end
          OP_BEQ, OP_BNE, OP_BLTZ: begin bus.ALUOp = 3'b001; bus.ExtSel = 2'b01; end
          OP_JAL:   bus.RegOut = JAL_REG_SEL;
          default:  ;
        endcase
      end
      case (cur)
        S_ID: begin
          bus.PCWre      = (cls == C_JMP) || (cls == C_NONE);
          bus.illegal_op = (cls == C_NONE);
          if (bus.op == OP_JAL) begin
            bus.RegWre    = 1'b1;
            bus.WrRegData = 1'b0;
          end
          if (bus.op == OP_J || bus.op == OP_JAL) bus.PCSrc = 2'b11;
          else if (bus.op == OP_JR)               bus.PCSrc = 2'b10;
        end
        S_EXE_BR: begin
          bus.PCWre = 1'b1;
          bus.PCSrc = taken ? 2'b01 : 2'b00;
        end
        S_MEM: begin
          bus.PCWre     = (bus.op != OP_LW);
          bus.DataMemRW = (bus.op == OP_SW);
        end
        S_WB_LD: begin
          bus.PCWre    = 1'b1;
          bus.RegWre   = 1'b1;
          bus.ALUM2Reg = 1'b1;
        end
        S_WB_AL: begin
          bus.PCWre  = 1'b1;
          bus.RegWre = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
